// File: rtl/mem_pkg.sv
// Shared types and helpers for the pipelined data memory: access-size encoding,
// latency ceiling and the byte-lane strobe generator.
package mem_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2,
      MEM_BAD  = 2'd3
   } mem_size_e;

   localparam int MEM_MAX_LAT = 4;

   // Byte-lane write strobe for an access of the given size at byte offset lo.
   function automatic logic [3:0] lane_mask(input mem_size_e size, input logic [1:0] lo);
      case (size)
         MEM_BYTE: lane_mask = 4'b0001 << lo;
         MEM_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
         MEM_WORD: lane_mask = 4'b1111;
         default:  lane_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane selection and sign/zero extension: picks the addressed byte or half out of
// an aligned 32-bit word and extends it to 32 bits.
module mem_load_align import mem_pkg::*; (
   input  logic [31:0] word,
   input  mem_size_e   size,
   input  logic [1:0]  lo,
   input  logic        uns,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[8*lo +: 8];
      half_sel = lo[1] ? word[31:16] : word[15:0];
      case (size)
         MEM_BYTE: data = {{24{byte_sel[7] & ~uns}}, byte_sel};
         MEM_HALF: data = {{16{half_sel[15] & ~uns}}, half_sel};
         MEM_WORD: data = word;
         default:  data = 32'h0;
      endcase
   end

endmodule

// File: rtl/pipelined_data_mem.sv
// Byte-addressable test memory with a never-stalling fetch port and a valid/ready data port.
// Optional MEM_PERF_CNT_EN adds saturating load/store/error access counters.
module pipelined_data_mem import mem_pkg::*; #(
   parameter int          SIZE       = 8192,
   parameter logic [31:0] START_ADDR = 32'h8000_0000,
   parameter int          READ_LAT   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_valid,
   input  logic [31:0] if_addr,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        d_req_valid,
   output logic        d_req_ready,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic        d_unsigned,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_resp_valid,
   input  logic        d_resp_ready,
   output logic [31:0] d_rdata,
   output logic        d_err
`ifdef MEM_PERF_CNT_EN
   ,
   output logic [31:0] cnt_load,
   output logic [31:0] cnt_store,
   output logic [31:0] cnt_err
`endif
);

   localparam int WORDS = SIZE / 4;
   localparam int AW    = $clog2(WORDS);
   localparam int LAT   = (READ_LAT < 1) ? 1 : ((READ_LAT > MEM_MAX_LAT) ? MEM_MAX_LAT : READ_LAT);

   logic [31:0] mem [WORDS];

   logic [31:0]   if_off;
   logic          if_bad;
   logic [AW-1:0] if_idx;
   logic          if_acc;
   logic [31:0]   if_new;

   mem_size_e     d_sz;
   logic [31:0]   d_off;
   logic          d_bad;
   logic [AW-1:0] d_idx;
   logic [3:0]    d_mask;
   logic [31:0]   d_wrep;
   logic [31:0]   d_word_rd;
   logic [31:0]   d_ld_data;
   logic [31:0]   d_new;
   logic          d_acc;
   logic          advance;

   logic          d_vld_p  [LAT];
   logic [31:0]   d_data_p [LAT];
   logic          d_err_p  [LAT];
   logic          if_vld_p [LAT];
   logic [31:0]   if_data_p[LAT];
   logic          if_err_p [LAT];

   // Address decode: offsets below START_ADDR wrap to huge values and fall out of range
   assign if_off = if_addr - START_ADDR;
   assign if_bad = (if_off >= 32'(SIZE)) || (if_addr[1:0] != 2'b00);
   assign if_idx = if_off[AW+1:2];
   assign if_acc = if_valid && !reset;
   assign if_new = if_bad ? 32'h0 : mem[if_idx];

   assign d_sz   = mem_size_e'(d_size);
   assign d_off  = d_addr - START_ADDR;
   assign d_bad  = (d_off >= 32'(SIZE)) || (d_sz == MEM_BAD) ||
                   ((d_sz == MEM_HALF) && d_addr[0]) ||
                   ((d_sz == MEM_WORD) && (d_addr[1:0] != 2'b00));
   assign d_idx  = d_off[AW+1:2];
   assign d_mask = lane_mask(d_sz, d_addr[1:0]);

   always_comb begin
      case (d_sz)
         MEM_BYTE: d_wrep = {4{d_wdata[7:0]}};
         MEM_HALF: d_wrep = {2{d_wdata[15:0]}};
         default:  d_wrep = d_wdata;
      endcase
   end

   assign d_word_rd = mem[d_idx];

   mem_load_align u_align (
      .word (d_word_rd),
      .size (d_sz),
      .lo   (d_addr[1:0]),
      .uns  (d_unsigned),
      .data (d_ld_data)
   );

   assign d_new       = (d_bad || d_we) ? 32'h0 : d_ld_data;
   assign advance     = !d_resp_valid || d_resp_ready;
   assign d_req_ready = advance && !reset;
   assign d_acc       = d_req_valid && d_req_ready;

   // Storage: reads above sample the pre-edge contents, so same-edge readers see old data
   always_ff @(posedge clk) begin
      if (d_acc && d_we && !d_bad) begin
         for (int i = 0; i < 4; i++) begin
            if (d_mask[i]) mem[d_idx][8*i +: 8] <= d_wrep[8*i +: 8];
         end
      end
   end

   // ---- stage p0 .. p(LAT-1): response shift registers ----
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LAT; i++) begin
            d_vld_p[i]   <= 1'b0;
            d_data_p[i]  <= 32'h0;
            d_err_p[i]   <= 1'b0;
            if_vld_p[i]  <= 1'b0;
            if_data_p[i] <= 32'h0;
            if_err_p[i]  <= 1'b0;
         end
      end else begin
         if (advance) begin
            d_vld_p[0]  <= d_acc;
            d_data_p[0] <= d_acc ? d_new : 32'h0;
            d_err_p[0]  <= d_acc && d_bad;
            for (int i = 1; i < LAT; i++) begin
               d_vld_p[i]  <= d_vld_p[i-1];
               d_data_p[i] <= d_data_p[i-1];
               d_err_p[i]  <= d_err_p[i-1];
            end
         end
         if_vld_p[0]  <= if_acc;
         if_data_p[0] <= if_acc ? if_new : 32'h0;
         if_err_p[0]  <= if_acc && if_bad;
         for (int i = 1; i < LAT; i++) begin
            if_vld_p[i]  <= if_vld_p[i-1];
            if_data_p[i] <= if_data_p[i-1];
            if_err_p[i]  <= if_err_p[i-1];
         end
      end
   end

   assign d_resp_valid = d_vld_p[LAT-1];
   assign d_rdata      = d_data_p[LAT-1];
   assign d_err        = d_err_p[LAT-1];
   assign if_rvalid    = if_vld_p[LAT-1];
   assign if_rdata     = if_data_p[LAT-1];
   assign if_err       = if_err_p[LAT-1];

`ifdef MEM_PERF_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_load  <= 32'h0;
         cnt_store <= 32'h0;
         cnt_err   <= 32'h0;
      end else if (d_acc) begin
         if (d_bad)     cnt_err   <= sat_inc(cnt_err);
         else if (d_we) cnt_store <= sat_inc(cnt_store);
         else           cnt_load  <= sat_inc(cnt_load);
      end
   end
`endif

endmodule

// File: tb/tb_pipelined_data_mem.sv
// Bench for pipelined_data_mem: directed scenarios plus a randomized phase, checked
// against a byte-array reference model with per-port expectation queues.
module tb_pipelined_data_mem;

   localparam int          SIZE  = 8192;
   localparam logic [31:0] START = 32'h8000_0000;
   localparam int          LAT   = 3;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_valid;
   logic [31:0] if_addr;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        d_req_valid;
   logic        d_req_ready;
   logic        d_we;
   logic [1:0]  d_size;
   logic        d_unsigned;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_resp_valid;
   logic        d_resp_ready;
   logic [31:0] d_rdata;
   logic        d_err;

   logic [7:0]  model [SIZE];
   exp_t        q_d[$];
   exp_t        q_f[$];
   logic [31:0] f_seen[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   logic        last_acc_d = 1'b0;
   logic [31:0] last_d = 32'h0;
   logic        last_e = 1'b0;
   logic [31:0] held;

   always #5 clk = ~clk;

   pipelined_data_mem #(.SIZE(SIZE), .START_ADDR(START), .READ_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .if_valid(if_valid), .if_addr(if_addr), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
      .d_size(d_size), .d_unsigned(d_unsigned), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
      .d_rdata(d_rdata), .d_err(d_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Reference model: plain little-endian byte array plus the access rules
   function automatic bit in_rng(input logic [31:0] a);
      logic [31:0] o;
      o = a - START;
      return o < 32'(SIZE);
   endfunction

   function automatic bit d_bad_m(input logic [1:0] sz, input logic [31:0] a);
      return !in_rng(a) || (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
      int o;
      int n;
      logic [31:0] v;
      o = int'(a - START);
      n = 1 << sz;
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = model[o+i];
      if (!uns && n < 4 && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      int o;
      o = int'(a - START);
      for (int i = 0; i < (1 << sz); i++) model[o+i] = wd[8*i +: 8];
   endtask

   // One clock: predict what the upcoming edge accepts, then step past it
   task automatic cycle();
      exp_t e;
      logic acc_f;
      logic acc_d;
      logic rst_s;
      @(negedge clk);
      acc_f = if_valid && !reset;
      acc_d = d_req_valid && d_req_ready && !reset;
      if (acc_f) begin
         e.err  = !in_rng(if_addr) || (if_addr[1:0] != 2'd0);
         e.data = e.err ? 32'h0 : m_load(2'd2, 1'b1, if_addr);
         e.due  = cyc + LAT;
         q_f.push_back(e);
      end
      if (acc_d) begin
         e.err  = d_bad_m(d_size, d_addr);
         e.data = (e.err || d_we) ? 32'h0 : m_load(d_size, d_unsigned, d_addr);
         e.due  = 0;
         q_d.push_back(e);
         if (d_we && !e.err) m_store(d_size, d_addr, d_wdata);
      end
      last_acc_d = acc_d;
      rst_s = reset;
      @(posedge clk);
      cyc++;
      if (rst_s) begin
         q_d.delete();
         q_f.delete();
      end
      #1;
   endtask

   task automatic d_op(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
      d_req_valid = 1'b1; d_we = we; d_size = sz; d_unsigned = uns; d_addr = a; d_wdata = wd;
      for (int i = 0; i < 50; i++) begin
         cycle();
         if (last_acc_d) break;
      end
      chk("d_accept", 32'(last_acc_d), 32'd1);
      d_req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (q_d.size() + q_f.size()) > 0; i++) cycle();
      chk("drain", 32'(q_d.size() + q_f.size()), 32'd0);
   endtask

   task automatic ld_chk(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] exp_v, input logic exp_e);
      d_op(1'b0, sz, uns, a, 32'h0);
      drain();
      chk(tag, last_d, exp_v);
      chk({tag, "_err"}, 32'(last_e), 32'(exp_e));
   endtask

   // Response monitor, sampling on the falling edge
   always @(negedge clk) begin
      if (q_f.size() > 0 && q_f[0].due == cyc) begin
         chk("if_rvalid", 32'(if_rvalid), 32'd1);
         chk("if_rdata", if_rdata, q_f[0].data);
         chk("if_err", 32'(if_err), 32'(q_f[0].err));
         f_seen.push_back(if_rdata);
         void'(q_f.pop_front());
      end else begin
         chk("if_rvalid_idle", 32'(if_rvalid), 32'd0);
         if (q_f.size() > 0 && q_f[0].due < cyc) begin
            chk("if_late", 32'(q_f[0].due), 32'(cyc));
            void'(q_f.pop_front());
         end
      end
      if (d_resp_valid) begin
         if (q_d.size() == 0) begin
            chk("d_spurious", 32'(d_resp_valid), 32'd0);
         end else begin
            chk("d_rdata", d_rdata, q_d[0].data);
            chk("d_err", 32'(d_err), 32'(q_d[0].err));
            if (d_resp_ready) begin
               last_d = d_rdata;
               last_e = d_err;
               void'(q_d.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] r;
      reset = 1'b1; if_valid = 1'b0; if_addr = START; d_req_valid = 1'b0; d_we = 1'b0;
      d_size = 2'd2; d_unsigned = 1'b0; d_addr = START; d_wdata = 32'h0; d_resp_ready = 1'b1;
      cycle();
      cycle();
      chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst_d_resp_valid", 32'(d_resp_valid), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_errs", {30'd0, if_err, d_err}, 32'd0);
      chk("rst_req_ready", 32'(d_req_ready), 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_req_ready", 32'(d_req_ready), 32'd1);

      // Known contents for the first 64 bytes
      for (int w = 0; w < 16; w++) d_op(1'b1, 2'd2, 1'b0, START + 32'(4*w), $urandom);
      drain();

      // Word store then load
      d_op(1'b1, 2'd2, 1'b0, START, 32'hDEADBEEF);
      ld_chk("lw_basic", 2'd2, 1'b0, START, 32'hDEADBEEF, 1'b0);

      // Byte store, signed/unsigned byte loads, lane isolation
      d_op(1'b1, 2'd0, 1'b0, START + 32'd1, 32'h0000_0080);
      ld_chk("lb", 2'd0, 1'b0, START + 32'd1, 32'hFFFF_FF80, 1'b0);
      ld_chk("lbu", 2'd0, 1'b1, START + 32'd1, 32'h0000_0080, 1'b0);
      ld_chk("lw_lane", 2'd2, 1'b0, START, 32'hDEAD80EF, 1'b0);

      // Error cases leave memory unchanged
      ld_chk("lh_misal", 2'd1, 1'b0, START + 32'd1, 32'h0, 1'b1);
      ld_chk("lw_below", 2'd2, 1'b0, 32'h7FFF_FFFC, 32'h0, 1'b1);
      d_op(1'b1, 2'd2, 1'b0, START + 32'd2, 32'hFFFF_FFFF);
      d_op(1'b1, 2'd3, 1'b0, START, 32'h1234_5678);
      ld_chk("lw_unchanged", 2'd2, 1'b0, START, 32'hDEAD80EF, 1'b0);

      // Back-pressure: fill the pipe, stall the consumer, then release
      d_resp_ready = 1'b0;
      d_op(1'b0, 2'd2, 1'b0, START + 32'd4, 32'h0);
      d_op(1'b0, 2'd2, 1'b0, START + 32'd8, 32'h0);
      d_op(1'b0, 2'd1, 1'b1, START + 32'd14, 32'h0);
      d_req_valid = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = START + 32'd12;
      chk("stall_valid", 32'(d_resp_valid), 32'd1);
      held = d_rdata;
      for (int i = 0; i < 4; i++) begin
         chk("stall_ready", 32'(d_req_ready), 32'd0);
         chk("stall_hold", d_rdata, held);
         cycle();
      end
      d_resp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (last_acc_d) break;
      end
      chk("stall_release_accept", 32'(last_acc_d), 32'd1);
      d_req_valid = 1'b0;
      drain();

      // Fetch and store to the same word on the same edge
      d_op(1'b1, 2'd2, 1'b0, START + 32'h10, 32'hCAFE_F00D);
      drain();
      f_seen.delete();
      if_valid = 1'b1; if_addr = START + 32'h10;
      d_req_valid = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = START + 32'h10; d_wdata = 32'h1122_3344;
      cycle();
      chk("same_edge_accept", 32'(last_acc_d), 32'd1);
      d_req_valid = 1'b0;
      cycle();
      if_valid = 1'b0;
      drain();
      chk("fetch_count", 32'(f_seen.size()), 32'd2);
      if (f_seen.size() == 2) begin
         chk("fetch_old", f_seen[0], 32'hCAFE_F00D);
         chk("fetch_new", f_seen[1], 32'h1122_3344);
      end

      // Reset with loads in flight; a store presented during reset is ignored
      d_op(1'b0, 2'd2, 1'b0, START, 32'h0);
      d_op(1'b0, 2'd2, 1'b0, START + 32'd4, 32'h0);
      reset = 1'b1;
      d_req_valid = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = START; d_wdata = 32'h5555_5555;
      if_valid = 1'b1; if_addr = START;
      cycle();
      cycle();
      chk("rst2_req_ready", 32'(d_req_ready), 32'd0);
      reset = 1'b0; d_req_valid = 1'b0; if_valid = 1'b0;
      for (int i = 0; i < LAT + 2; i++) begin
         cycle();
         chk("rst2_no_resp", 32'(d_resp_valid), 32'd0);
      end
      ld_chk("lw_retained", 2'd2, 1'b0, START, 32'hDEAD80EF, 1'b0);

      // Randomized traffic on both ports with random back-pressure
      for (int k = 0; k < 400; k++) begin
         d_req_valid = ($urandom_range(0, 9) < 7);
         d_we = ($urandom_range(0, 2) == 0);
         r = 4'($urandom_range(0, 9));
         d_size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         d_unsigned = 1'($urandom_range(0, 1));
         d_wdata = $urandom;
         if ($urandom_range(0, 19) == 0)
            d_addr = ($urandom_range(0, 1) == 0) ? START - 32'd4 : START + 32'(SIZE) + 32'($urandom_range(0, 15));
         else
            d_addr = START + 32'($urandom_range(0, 63));
         d_resp_ready = ($urandom_range(0, 3) != 0);
         if_valid = 1'($urandom_range(0, 1));
         if_addr = START + 32'(4 * $urandom_range(0, 15)) + (($urandom_range(0, 9) == 0) ? 32'd2 : 32'd0);
         cycle();
      end
      d_req_valid = 1'b0; if_valid = 1'b0; d_resp_ready = 1'b1;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
